// File: rtl/matvec_mac_engine_if.sv
// Handshake bundle between the operand buffers, the matvec_mac_engine and the result register file.
// The engine takes the slave view; whoever feeds operands and drains results takes the master view.
interface matvec_mac_engine_if #(
    parameter int ROWS      = 4,
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8
);
    logic                            signed_mode;
    logic                            in_valid;
    logic                            in_ready;
    logic [ROWS*LANES*IN_WIDTH-1:0]  mat_slice;
    logic [LANES*IN_WIDTH-1:0]       vec_slice;
    logic                            out_valid;
    logic                            out_ready;
    logic [ROWS*OUT_WIDTH-1:0]       y;
    logic [ROWS-1:0]                 sat;
    logic                            busy;

    modport slave (
        input  signed_mode, in_valid, mat_slice, vec_slice, out_ready,
        output in_ready, out_valid, y, sat, busy
    );

    modport master (
        output signed_mode, in_valid, mat_slice, vec_slice, out_ready,
        input  in_ready, out_valid, y, sat, busy
    );
endinterface

// File: rtl/matvec_mac_engine.sv
// Streaming matrix-vector multiply-accumulate: consumes COLUMNS/LANES column slices per vector,
// accumulates each row at full precision, then rounds, shifts and saturates into one result vector.
module matvec_mac_engine #(
    parameter int ROWS      = 4,
    parameter int COLUMNS   = 8,
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 2 * IN_WIDTH + $clog2(COLUMNS),
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    matvec_mac_engine_if.slave   bus
);

    localparam int BEATS  = COLUMNS / LANES;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int PROD_W = 2 * IN_WIDTH + 2;
    localparam int QW     = ACC_WIDTH + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [QW-1:0]        RND   = (SHIFT > 0) ? (QW'(1) << RND_SH) : '0;
    localparam logic signed [QW-1:0] S_MAX = QW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [QW-1:0] S_MIN = ~S_MAX;
    localparam logic [QW-1:0]        U_MAX = QW'((2 ** OUT_WIDTH) - 1);

    if (SHIFT < 0 || SHIFT >= ACC_WIDTH || (COLUMNS % LANES) != 0 || OUT_WIDTH > ACC_WIDTH)
    begin : g_param_check
        $error("matvec_mac_engine: SHIFT out of range or COLUMNS not a multiple of LANES");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_e;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] y;
        logic                 sat;
    } quant_t;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q;
    logic                            mode_q;
    logic [ROWS-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ROWS-1:0][OUT_WIDTH-1:0]  y_q, y_d;
    logic [ROWS-1:0]                 sat_q, sat_d;

    logic in_ready;
    logic out_valid;
    logic busy;
    logic accept;
    logic last_beat;
    logic eff_signed;

    // Round half-up, shift (arithmetic or logical per mode), then clip to the result range.
    function automatic quant_t requant(input logic [ACC_WIDTH-1:0] acc, input logic sgn);
        logic [QW-1:0] ext;
        logic [QW-1:0] sum;
        logic [QW-1:0] t;
        quant_t        q;
        ext = sgn ? {acc[ACC_WIDTH-1], acc} : {1'b0, acc};
        sum = ext + RND;
        if (sgn) t = $signed(sum) >>> SHIFT;
        else     t = sum >> SHIFT;
        q.y   = t[OUT_WIDTH-1:0];
        q.sat = 1'b0;
        if (sgn) begin
            if ($signed(t) > S_MAX) begin
                q.y   = S_MAX[OUT_WIDTH-1:0];
                q.sat = 1'b1;
            end else if ($signed(t) < S_MIN) begin
                q.y   = S_MIN[OUT_WIDTH-1:0];
                q.sat = 1'b1;
            end
        end else if (t > U_MAX) begin
            q.y   = U_MAX[OUT_WIDTH-1:0];
            q.sat = 1'b1;
        end
        return q;
    endfunction

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting every combinational output first keeps paths that skip an assignment from inferring latches.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_ACCUM: begin
                if (last_beat)   state_d = S_OUTPUT;
                else if (accept) state_d = S_ACCUM;
            end
            S_OUTPUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = ~rst;
            end
            S_ACCUM: begin
                in_ready = ~rst;
                busy     = 1'b1;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;

    // ------------------------------------------------------------- datapath
    assign accept     = bus.in_valid & in_ready;
    assign last_beat  = accept && ((state_q == S_IDLE) ? (BEATS == 1)
                                                       : (cnt_q == CNT_W'(BEATS - 1)));
    // The first beat uses the live mode input; later beats use the mode latched on that beat.
    assign eff_signed = (state_q == S_IDLE) ? bus.signed_mode : mode_q;

    always_comb begin
        logic [IN_WIDTH-1:0]        a;
        logic [IN_WIDTH-1:0]        b;
        logic signed [IN_WIDTH:0]   a_x;
        logic signed [IN_WIDTH:0]   b_x;
        logic signed [PROD_W-1:0]   p;
        logic [ACC_WIDTH-1:0]       beat_sum;
        quant_t                     q;
        a        = '0;
        b        = '0;
        a_x      = '0;
        b_x      = '0;
        p        = '0;
        beat_sum = '0;
        q        = '0;
        acc_d    = '0;
        y_d      = '0;
        sat_d    = '0;
        for (int r = 0; r < ROWS; r++) begin
            beat_sum = '0;
            for (int l = 0; l < LANES; l++) begin
                a        = bus.mat_slice[(r*LANES + l)*IN_WIDTH +: IN_WIDTH];
                b        = bus.vec_slice[l*IN_WIDTH +: IN_WIDTH];
                a_x      = {eff_signed & a[IN_WIDTH-1], a};
                b_x      = {eff_signed & b[IN_WIDTH-1], b};
                p        = a_x * b_x;
                beat_sum = beat_sum + ACC_WIDTH'(p);
            end
            acc_d[r] = ((state_q == S_IDLE) ? '0 : acc_q[r]) + beat_sum;
            q        = requant(acc_d[r], eff_signed);
            y_d[r]   = q.y;
            sat_d[r] = q.sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator bank is reset so an aborted vector can never leak partial sums.
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            y_q    <= '0;
            sat_q  <= '0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
                if (state_q == S_IDLE) begin
                    cnt_q  <= CNT_W'(1);
                    mode_q <= bus.signed_mode;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (last_beat) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Directed bench for matvec_mac_engine: three instances (SHIFT 0, 2, 3) share one stimulus stream
// so each scenario can be checked against the shift setting it targets.
module tb_matvec_mac_engine;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 8;
    localparam int LANES   = 4;
    localparam int IW      = 8;
    localparam int OW      = 8;

    logic clk = 1'b0;
    logic rst;
    logic sm;
    logic in_valid;
    logic out_ready;
    logic [ROWS*LANES*IW-1:0] mat;
    logic [LANES*IW-1:0]      vec;

    int checks   = 0;
    int failures = 0;
    int m [ROWS][COLUMNS];
    int v [COLUMNS];

    always #5 clk = ~clk;

    matvec_mac_engine_if #(.ROWS(ROWS), .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus0 ();
    matvec_mac_engine_if #(.ROWS(ROWS), .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus2 ();
    matvec_mac_engine_if #(.ROWS(ROWS), .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus3 ();

    assign bus0.signed_mode = sm;
    assign bus0.in_valid    = in_valid;
    assign bus0.mat_slice   = mat;
    assign bus0.vec_slice   = vec;
    assign bus0.out_ready   = out_ready;
    assign bus2.signed_mode = sm;
    assign bus2.in_valid    = in_valid;
    assign bus2.mat_slice   = mat;
    assign bus2.vec_slice   = vec;
    assign bus2.out_ready   = out_ready;
    assign bus3.signed_mode = sm;
    assign bus3.in_valid    = in_valid;
    assign bus3.mat_slice   = mat;
    assign bus3.vec_slice   = vec;
    assign bus3.out_ready   = out_ready;

    matvec_mac_engine #(.ROWS(ROWS), .COLUMNS(COLUMNS), .LANES(LANES), .IN_WIDTH(IW),
                        .OUT_WIDTH(OW), .SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    matvec_mac_engine #(.ROWS(ROWS), .COLUMNS(COLUMNS), .LANES(LANES), .IN_WIDTH(IW),
                        .OUT_WIDTH(OW), .SHIFT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    matvec_mac_engine #(.ROWS(ROWS), .COLUMNS(COLUMNS), .LANES(LANES), .IN_WIDTH(IW),
                        .OUT_WIDTH(OW), .SHIFT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mv, input int vv);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++) m[r][c] = mv;
        for (int c = 0; c < COLUMNS; c++) v[c] = vv;
    endtask

    task automatic load_beat(input int b);
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < LANES; l++)
                mat[(r*LANES + l)*IW +: IW] = IW'(m[r][b*LANES + l]);
        for (int l = 0; l < LANES; l++)
            vec[l*IW +: IW] = IW'(v[b*LANES + l]);
    endtask

    // Called on a falling edge; returns on the falling edge after the beat was taken.
    task automatic accept_beat(input int b);
        int n;
        load_beat(b);
        in_valid = 1'b1;
        n = 0;
        while (bus0.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_for_beat", bus0.in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input logic mode_first, input logic mode_second);
        sm = mode_first;
        accept_beat(0);
        sm = mode_second;
        accept_beat(1);
        sm = mode_first;
    endtask

    task automatic retire();
        int n;
        n = 0;
        while (bus0.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_before_retire", bus0.out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", bus0.in_ready, 1'b1);
        check("out_valid_after_handshake", bus0.out_valid, 1'b0);
    endtask

    task automatic set_identity();
        fill(0, 0);
        for (int r = 0; r < ROWS; r++) m[r][r] = 1;
        for (int c = 0; c < COLUMNS; c++) v[c] = c + 1;
    endtask

    task automatic set_upper();
        fill(0, 0);
        for (int r = 0; r < ROWS; r++) m[r][r+4] = 2;
        for (int c = 0; c < COLUMNS; c++) v[c] = c + 1;
    endtask

    task automatic set_rounding();
        fill(0, 1);
        m[0][0] = 3;  m[0][5] = 3;
        m[1][2] = -6;
        m[2][7] = 5;
        m[3][1] = -4; m[3][6] = -3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sm = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mat = '0; vec = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", bus0.in_ready, 1'b0);
        check("rst_out_valid", bus0.out_valid, 1'b0);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_y", bus0.y, 32'h0);
        check("rst_sat", bus0.sat, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus0.in_ready, 1'b1);

        // 1: identity-like rows, result one cycle after the second beat
        set_identity();
        sm = 1'b1;
        load_beat(0);
        in_valid = 1'b1;
        @(negedge clk);
        check("t1_out_valid_mid", bus0.out_valid, 1'b0);
        check("t1_busy_mid", bus0.busy, 1'b1);
        load_beat(1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_out_valid", bus0.out_valid, 1'b1);
        check("t1_y", bus0.y, 32'h04030201);
        check("t1_sat", bus0.sat, 4'h0);
        retire();

        // 2: signed saturation both directions
        fill(127, 127);
        send_vector(1'b1, 1'b1);
        check("t2_pos_y", bus0.y, 32'h7F7F7F7F);
        check("t2_pos_sat", bus0.sat, 4'hF);
        retire();
        fill(-128, 127);
        send_vector(1'b1, 1'b1);
        check("t2_neg_y", bus0.y, 32'h80808080);
        check("t2_neg_sat", bus0.sat, 4'hF);
        retire();

        // 3: rounding; row sums 6, -6, 5, -7
        set_rounding();
        send_vector(1'b1, 1'b1);
        check("t3_sh0_y", bus0.y, 32'hF905FA06);
        check("t3_sh2_y", bus2.y, 32'hFE01FF02);
        check("t3_sh2_sat", bus2.sat, 4'h0);
        check("t3_sh3_y", bus3.y, 32'hFF01FF01);
        retire();

        // 4: unsigned mode; the mode flip on the second beat must be ignored
        fill(255, 1);
        send_vector(1'b0, 1'b1);
        check("t4_sh3_y", bus3.y, 32'hFFFFFFFF);
        check("t4_sh3_sat", bus3.sat, 4'h0);
        check("t4_sh0_sat", bus0.sat, 4'hF);
        retire();
        fill(255, 2);
        send_vector(1'b0, 1'b0);
        check("t4_sh3_clip_y", bus3.y, 32'hFFFFFFFF);
        check("t4_sh3_clip_sat", bus3.sat, 4'hF);
        retire();

        // 5: input bubble, output backpressure, then a back-to-back vector
        set_upper();
        sm = 1'b1;
        load_beat(0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_bubble_in_ready", bus0.in_ready, 1'b1);
        check("t5_bubble_busy", bus0.busy, 1'b1);
        @(negedge clk);
        check("t5_bubble_out_valid", bus0.out_valid, 1'b0);
        load_beat(1);
        in_valid = 1'b1;
        @(negedge clk);
        mat = '1;
        vec = '1;
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_out_valid", bus0.out_valid, 1'b1);
            check("t5_hold_in_ready", bus0.in_ready, 1'b0);
            check("t5_hold_y", bus0.y, 32'h100E0C0A);
            check("t5_hold_sat", bus0.sat, 4'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        retire();
        set_identity();
        send_vector(1'b1, 1'b1);
        check("t5_b2b_y", bus0.y, 32'h04030201);
        retire();

        // 6: reset after the first of two beats discards the partial sums
        set_rounding();
        sm = 1'b1;
        load_beat(0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_y", bus0.y, 32'h0);
        check("t6_rst_sat", bus0.sat, 4'h0);
        check("t6_rst_out_valid", bus0.out_valid, 1'b0);
        check("t6_rst_in_ready", bus0.in_ready, 1'b0);
        check("t6_rst_busy", bus0.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_out_valid", bus0.out_valid, 1'b0);
        set_upper();
        send_vector(1'b1, 1'b1);
        check("t6_y", bus0.y, 32'h100E0C0A);
        check("t6_sat", bus0.sat, 4'h0);
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
